// File: rtl/conv_pkg.sv
// Shared definitions for the binary-convolution result packer.
//   WORD_W / TILE_W    : packed output word width and 2x2 result tile width
//   DEFAULT_ADDR_W     : default output SRAM address width
//   QUADn_BASE         : word bit that receives the top-left pixel of quad n
//   packer_state_e     : packer FSM state encoding
//   quad_base()        : quad index -> base bit
//   popcount16()       : number of set bits in a packed word
package conv_pkg;

    localparam int unsigned WORD_W         = 16;
    localparam int unsigned TILE_W         = 4;
    localparam int unsigned DEFAULT_ADDR_W = 12;

    // A 4x4 word is stored row-major (bit = row*4 + col); each 2x2 quad starts here.
    localparam logic [3:0] QUAD0_BASE = 4'd0;
    localparam logic [3:0] QUAD1_BASE = 4'd2;
    localparam logic [3:0] QUAD2_BASE = 4'd8;
    localparam logic [3:0] QUAD3_BASE = 4'd10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } packer_state_e;

    function automatic logic [3:0] quad_base(input logic [1:0] quad);
        logic [3:0] base;
        unique case (quad)
            2'd0:    base = QUAD0_BASE;
            2'd1:    base = QUAD1_BASE;
            2'd2:    base = QUAD2_BASE;
            default: base = QUAD3_BASE;
        endcase
        return base;
    endfunction

    function automatic logic [4:0] popcount16(input logic [WORD_W-1:0] word);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < WORD_W; i++) begin
            cnt = cnt + {4'd0, word[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/packer_tile_place.sv
// Scatters one 2x2 result tile into its position inside a 4x4 packed word.
//   in_tile [3:0] : bit0 TL, bit1 TR, bit2 LL, bit3 LR
//   quad    [1:0] : which quadrant of the word this tile belongs to
//   mask   [15:0] : tile bits placed at base+0, base+1, base+4, base+5
// Purely combinational.
module packer_tile_place
    import conv_pkg::*;
(
    input  logic [TILE_W-1:0] in_tile,
    input  logic [1:0]        quad,
    output logic [WORD_W-1:0] mask
);

    logic [WORD_W-1:0] pattern;

    always_comb begin
        // Tile laid out as it sits at quad 0: row 0 cols 0..1, row 1 cols 0..1.
        pattern = {10'd0, in_tile[3:2], 2'b00, in_tile[1:0]};
        mask    = pattern << quad_base(quad);
    end

endmodule

// File: rtl/conv_result_packer.sv
// Collects 2x2 convolution result tiles, packs four per 16-bit 4x4 word and writes each
// word to output SRAM at base + block index. Flags the last write of a frame.
// Optional feature macro: PACKER_ONES_COUNT_EN adds ones_count (set bits written in the
// current frame, saturating).
// Ports:
//   clk, reset (sync, active-high)
//   start, cfg_base_addr         : frame start pulse and base address (IDLE only)
//   in_valid, in_ready, in_tile  : tile stream
//   sram_write_en/address/data   : registered SRAM write port, no backpressure
//   busy, frame_done             : frame status
//   ones_count                   : (PACKER_ONES_COUNT_EN only)
module conv_result_packer
    import conv_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = 16,
    parameter int unsigned ADDR_W     = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TILE_W-1:0] in_tile,
    output logic              sram_write_en,
    output logic [ADDR_W-1:0] sram_write_address,
    output logic [WORD_W-1:0] sram_write_data,
    output logic              busy,
`ifdef PACKER_ONES_COUNT_EN
    output logic [15:0]       ones_count,
`endif
    output logic              frame_done
);

    localparam int unsigned CNT_W = 13;
    localparam logic [CNT_W-1:0] LAST_BLOCK = CNT_W'(NUM_BLOCKS - 1);

    packer_state_e     state_q, state_d;
    logic [1:0]        quad_q;
    logic [CNT_W-1:0]  block_cnt_q;
    logic [WORD_W-1:0] acc_q;
    logic [ADDR_W-1:0] base_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] data_q;
    logic              done_q;

    logic [WORD_W-1:0] tile_mask;
    logic [WORD_W-1:0] word;
    logic              xfer;
    logic              write_now;
    logic              frame_end;
    logic              start_ok;

    packer_tile_place u_tile_place (
        .in_tile (in_tile),
        .quad    (quad_q),
        .mask    (tile_mask)
    );

    always_comb begin
        start_ok  = (state_q == IDLE) && start;
        xfer      = (state_q == RUN) && in_valid;
        word      = acc_q | tile_mask;
        write_now = xfer && (quad_q == 2'd3);
        frame_end = write_now && (block_cnt_q == LAST_BLOCK);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (frame_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quad_q      <= '0;
            block_cnt_q <= '0;
            acc_q       <= '0;
            base_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            we_q   <= write_now;
            done_q <= frame_end;
            if (start_ok) begin
                base_q      <= cfg_base_addr;
                quad_q      <= '0;
                block_cnt_q <= '0;
                acc_q       <= '0;
            end else if (xfer) begin
                quad_q <= quad_q + 2'd1;
                if (write_now) begin
                    // Clearing here lets the next cycle's tile begin a new word.
                    acc_q       <= '0;
                    addr_q      <= base_q + ADDR_W'(block_cnt_q);
                    data_q      <= word;
                    block_cnt_q <= frame_end ? '0 : block_cnt_q + CNT_W'(1);
                end else begin
                    acc_q <= word;
                end
            end
        end
    end

`ifdef PACKER_ONES_COUNT_EN
    logic [15:0] ones_q;
    logic [16:0] ones_sum;

    always_comb begin
        ones_sum = {1'b0, ones_q} + {12'd0, popcount16(word)};
    end

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            ones_q <= '0;
        end else if (write_now) begin
            ones_q <= ones_sum[16] ? 16'hFFFF : ones_sum[15:0];
        end
    end

    assign ones_count = ones_q;
`endif

    assign in_ready           = (state_q == RUN);
    assign busy               = (state_q == RUN);
    assign sram_write_en      = we_q;
    assign sram_write_address = addr_q;
    assign sram_write_data    = data_q;
    assign frame_done         = done_q;

endmodule

// File: tb/tb_conv_result_packer.sv
// Self-checking bench for conv_result_packer (NUM_BLOCKS=2). A transaction-level model
// places each accepted tile by row/column arithmetic and predicts every cycle's outputs.
module tb_conv_result_packer;

    localparam int unsigned NB = 2;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] cfg_base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_tile;
    logic        sram_write_en;
    logic [11:0] sram_write_address;
    logic [15:0] sram_write_data;
    logic        busy;
    logic        frame_done;
`ifdef PACKER_ONES_COUNT_EN
    logic [15:0] ones_count;
`endif

    conv_result_packer #(
        .NUM_BLOCKS (NB),
        .ADDR_W     (12)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .cfg_base_addr      (cfg_base_addr),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_tile            (in_tile),
        .sram_write_en      (sram_write_en),
        .sram_write_address (sram_write_address),
        .sram_write_data    (sram_write_data),
        .busy               (busy),
`ifdef PACKER_ONES_COUNT_EN
        .ones_count         (ones_count),
`endif
        .frame_done         (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    bit          m_run = 0;
    logic [11:0] m_base = '0;
    int          m_n = 0;
    logic [15:0] m_word = '0;
    logic        e_we = 0, e_done = 0;
    logic [11:0] e_addr = '0;
    logic [15:0] e_data = '0;
    int          e_ones = 0;

    logic [11:0] obs_addr[$];
    logic [15:0] obs_data[$];
    logic [3:0]  tiles[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word bits produced by tile t in quad q of a 4x4 row-major block.
    function automatic logic [15:0] tile_bits(input int q, input logic [3:0] t);
        logic [15:0] w;
        int row, col;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            row = (q / 2) * 2 + b / 2;
            col = (q % 2) * 2 + b % 2;
            if (t[b]) w[row * 4 + col] = 1'b1;
        end
        return w;
    endfunction

    task automatic cycle(input logic rst, input logic st, input logic [11:0] b,
                         input logic v, input logic [3:0] t);
        reset = rst; start = st; cfg_base_addr = b; in_valid = v; in_tile = t;
        e_we = 0; e_done = 0;
        if (rst) begin
            m_run = 0; m_n = 0; m_word = '0;
            e_addr = '0; e_data = '0; e_ones = 0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1; m_base = b; m_n = 0; m_word = '0; e_ones = 0;
            end
        end else if (v) begin
            m_word = m_word | tile_bits(m_n % 4, t);
            m_n++;
            if (m_n % 4 == 0) begin
                e_we   = 1;
                e_addr = 12'(int'(m_base) + m_n / 4 - 1);
                e_data = m_word;
                e_ones = e_ones + $countones(m_word);
                if (e_ones > 16'hFFFF) e_ones = 16'hFFFF;
                m_word = '0;
                if (m_n / 4 == NB) begin
                    e_done = 1; m_run = 0;
                end
            end
        end
        @(negedge clk);
        check_eq("write_en", 32'(sram_write_en), 32'(e_we));
        check_eq("write_addr", 32'(sram_write_address), 32'(e_addr));
        check_eq("write_data", 32'(sram_write_data), 32'(e_data));
        check_eq("frame_done", 32'(frame_done), 32'(e_done));
        check_eq("busy", 32'(busy), 32'(m_run));
        check_eq("in_ready", 32'(in_ready), 32'(m_run));
`ifdef PACKER_ONES_COUNT_EN
        check_eq("ones_count", 32'(ones_count), 32'(e_ones));
`endif
        if (sram_write_en) begin
            obs_addr.push_back(sram_write_address);
            obs_data.push_back(sram_write_data);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 12'h0, 0, 4'h0);
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
    endtask

    // Expected packed word for block k of the tiles queue.
    function automatic logic [15:0] block_word(input int k);
        logic [15:0] w;
        w = '0;
        for (int q = 0; q < 4; q++) w = w | tile_bits(q, tiles[k * 4 + q]);
        return w;
    endfunction

    initial begin
        reset = 1; start = 0; cfg_base_addr = '0; in_valid = 0; in_tile = '0;

        // Reset state
        cycle(1, 0, 12'h0, 0, 4'h0);
        cycle(1, 1, 12'h123, 1, 4'hF);
        idle(1);

        // Directed: F,0,0,0 then 1,2,4,8, back to back
        clear_obs();
        cycle(0, 1, 12'h100, 0, 4'h0);
        cycle(0, 0, 12'h0, 1, 4'hF);
        cycle(0, 0, 12'h0, 1, 4'h0);
        cycle(0, 0, 12'h0, 1, 4'h0);
        cycle(0, 0, 12'h0, 1, 4'h0);
        cycle(0, 0, 12'h0, 1, 4'h1);
        cycle(0, 0, 12'h0, 1, 4'h2);
        cycle(0, 0, 12'h0, 1, 4'h4);
        cycle(0, 0, 12'h0, 1, 4'h8);
        check_eq("t1_done_pulse", 32'(frame_done), 32'd1);
        idle(1);
        check_eq("t3_ready_after", 32'(in_ready), 32'd0);
        idle(1);
        check_eq("t1_nwrites", 32'(obs_addr.size()), 32'd2);
        if (obs_addr.size() == 2) begin
            check_eq("t1_addr0", 32'(obs_addr[0]), 32'h100);
            check_eq("t1_data0", 32'(obs_data[0]), 32'h0033);
            check_eq("t2_addr1", 32'(obs_addr[1]), 32'h101);
            check_eq("t2_data1", 32'(obs_data[1]), 32'h9009);
        end

        // Random gaps, IDLE tiles dropped, start in RUN ignored
        tiles.delete();
        for (int i = 0; i < 4 * NB; i++) tiles.push_back(4'($urandom));
        clear_obs();
        for (int i = 0; i < 3; i++) cycle(0, 0, 12'h0, 1, 4'($urandom));
        cycle(0, 1, 12'h2A0, 1, 4'hF);
        begin
            int k = 0;
            for (int i = 0; i < 300 && k < 4 * NB; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    cycle(0, 1'($urandom), 12'($urandom), 0, 4'($urandom));
                end else begin
                    cycle(0, 1'($urandom), 12'($urandom), 1, tiles[k]);
                    k++;
                end
            end
            check_eq("t4_all_sent", 32'(k), 32'(4 * NB));
        end
        idle(2);
        check_eq("t4_nwrites", 32'(obs_addr.size()), 32'(NB));
        for (int k = 0; k < NB && k < obs_data.size(); k++) begin
            check_eq("t4_word", 32'(obs_data[k]), 32'(block_word(k)));
            check_eq("t4_addr", 32'(obs_addr[k]), 32'(12'h2A0 + 12'(k)));
        end

        // Address wrap
        clear_obs();
        cycle(0, 1, 12'hFFF, 0, 4'h0);
        for (int i = 0; i < 4 * NB; i++) cycle(0, 0, 12'h0, 1, 4'($urandom));
        idle(2);
        check_eq("t5_nwrites", 32'(obs_addr.size()), 32'd2);
        if (obs_addr.size() == 2) begin
            check_eq("t5_addr0", 32'(obs_addr[0]), 32'hFFF);
            check_eq("t5_addr1", 32'(obs_addr[1]), 32'h000);
        end

        // Reset mid-word discards the partial word
        clear_obs();
        cycle(0, 1, 12'h020, 0, 4'h0);
        cycle(0, 0, 12'h0, 1, 4'hF);
        cycle(0, 0, 12'h0, 1, 4'hF);
        cycle(1, 0, 12'h0, 0, 4'h0);
        check_eq("t6_no_write", 32'(obs_addr.size()), 32'd0);
        cycle(0, 1, 12'h020, 0, 4'h0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 12'h0, 1, 4'h1);
        idle(1);
        check_eq("t6_nwrites", 32'(obs_addr.size()), 32'd1);
        if (obs_addr.size() == 1) begin
            check_eq("t6_addr", 32'(obs_addr[0]), 32'h020);
            check_eq("t6_data", 32'(obs_data[0]), 32'h0505);
        end
        cycle(1, 0, 12'h0, 0, 4'h0);

        // Random frames, checked cycle by cycle against the model
        for (int f = 0; f < 6; f++) begin
            cycle(0, 1, 12'($urandom), 0, 4'h0);
            for (int i = 0; i < 60 && m_run; i++)
                cycle(0, 1'($urandom), 12'($urandom), 1'($urandom_range(0, 3) != 0),
                      4'($urandom));
            check_eq("rnd_frame_end", 32'(busy), 32'd0);
            idle($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
